// File: rtl/logic_cmp_unit_pkg.sv
// Shared opcode/state types for logic_cmp_unit; holds no WIDTH-dependent items.
package logic_pkg;

  localparam int LOGIC_OP_W = 4;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_NOR  = 4'd2,
    OP_NOT1 = 4'd3,
    OP_NOT2 = 4'd4,
    OP_XOR  = 4'd5,
    OP_XNOR = 4'd6,
    OP_RSV7 = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ROL  = 4'd10,
    OP_ROR  = 4'd11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/logic_cmp_unit_if.sv
// Request/result bus of logic_cmp_unit. cmp_signed exists only when LOGIC_SIGNED_CMP_EN is defined.
interface logic_cmp_unit_if #(
  parameter int WIDTH = 16
);
  import logic_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      op1;
  logic [WIDTH-1:0]      op2;
  logic [LOGIC_OP_W-1:0] opcode;
`ifdef LOGIC_SIGNED_CMP_EN
  logic                  cmp_signed;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      result;
  logic                  za, zb, eq, gt, lt, zr;

  modport master (
    output in_valid, op1, op2, opcode, out_ready,
`ifdef LOGIC_SIGNED_CMP_EN
    output cmp_signed,
`endif
    input  in_ready, out_valid, result, za, zb, eq, gt, lt, zr
  );

  modport slave (
    input  in_valid, op1, op2, opcode, out_ready,
`ifdef LOGIC_SIGNED_CMP_EN
    input  cmp_signed,
`endif
    output in_ready, out_valid, result, za, zb, eq, gt, lt, zr
  );

endinterface

// File: rtl/logic_cmp_unit_flags.sv
// Combinational operand compare flags; signed compare only when LOGIC_SIGNED_CMP_EN is defined.
module logic_cmp_flags #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef LOGIC_SIGNED_CMP_EN
  input  logic             i_signed,
`endif
  output logic             o_za,
  output logic             o_zb,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_lt
);

  assign o_za = (i_a == '0);
  assign o_zb = (i_b == '0);
  assign o_eq = (i_a == i_b);

`ifdef LOGIC_SIGNED_CMP_EN
  assign o_gt = i_signed ? ($signed(i_a) > $signed(i_b)) : (i_a > i_b);
  assign o_lt = i_signed ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
`else
  assign o_gt = (i_a > i_b);
  assign o_lt = (i_a < i_b);
`endif

endmodule

// File: rtl/logic_cmp_unit.sv
// Logic/shift unit with compare flags and valid/ready handshake; shifts move one bit per cycle.
// Optional signed compare is enabled with LOGIC_SIGNED_CMP_EN.
module logic_cmp_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  logic_cmp_unit_if.slave bus
);

  state_e                r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_a, r_b, r_work, r_result;
  logic [LOGIC_OP_W-1:0] r_opcode;
  logic [SW-1:0]         r_cnt;
  logic                  r_za, r_zb, r_eq, r_gt, r_lt, r_zr;
  logic                  w_accept, w_load, w_is_shift;
  logic [SW-1:0]         w_n;
  logic [WIDTH-1:0]      w_step, w_res, w_fa, w_fb;
  logic                  w_za, w_zb, w_eq, w_gt, w_lt;
`ifdef LOGIC_SIGNED_CMP_EN
  logic                  r_sgn, w_fs;
`endif

  function automatic logic [WIDTH-1:0] f_logic(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [LOGIC_OP_W-1:0] op);
    case (op)
      OP_AND:  f_logic = a & b;
      OP_OR:   f_logic = a | b;
      OP_NOR:  f_logic = ~(a | b);
      OP_NOT1: f_logic = ~a;
      OP_NOT2: f_logic = ~b;
      OP_XOR:  f_logic = a ^ b;
      OP_XNOR: f_logic = ~(a ^ b);
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: f_logic = a;  // zero-distance shift
      default: f_logic = '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] w,
                                              input logic [LOGIC_OP_W-1:0] op);
    case (op)
      OP_SHL:  f_step = {w[WIDTH-2:0], 1'b0};
      OP_SHR:  f_step = {1'b0, w[WIDTH-1:1]};
      OP_ROL:  f_step = {w[WIDTH-2:0], w[WIDTH-1]};
      OP_ROR:  f_step = {w[0], w[WIDTH-1:1]};
      default: f_step = w;
    endcase
  endfunction

  assign w_is_shift = (bus.opcode[3:2] == 2'b10);
  assign w_n        = bus.op2[SW-1:0];
  assign w_step     = f_step(r_work, r_opcode);

  // Flags/result are loaded from live inputs when DONE is entered straight from IDLE.
  assign w_res = (r_state == ST_IDLE) ? f_logic(bus.op1, bus.op2, bus.opcode) : w_step;
  assign w_fa  = (r_state == ST_IDLE) ? bus.op1 : r_a;
  assign w_fb  = (r_state == ST_IDLE) ? bus.op2 : r_b;
`ifdef LOGIC_SIGNED_CMP_EN
  assign w_fs  = (r_state == ST_IDLE) ? bus.cmp_signed : r_sgn;
`endif

  logic_cmp_flags #(.WIDTH(WIDTH)) u_flags (
    .i_a      (w_fa),
    .i_b      (w_fb),
`ifdef LOGIC_SIGNED_CMP_EN
    .i_signed (w_fs),
`endif
    .o_za     (w_za),
    .o_zb     (w_zb),
    .o_eq     (w_eq),
    .o_gt     (w_gt),
    .o_lt     (w_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (w_is_shift && (w_n != '0)) begin
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_DONE;
            w_load      = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (r_cnt == SW'(1)) begin
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_opcode <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_za     <= 1'b0;
      r_zb     <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
      r_zr     <= 1'b0;
`ifdef LOGIC_SIGNED_CMP_EN
      r_sgn    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a      <= bus.op1;
        r_b      <= bus.op2;
        r_work   <= bus.op1;
        r_opcode <= bus.opcode;
        r_cnt    <= w_is_shift ? w_n : '0;
`ifdef LOGIC_SIGNED_CMP_EN
        r_sgn    <= bus.cmp_signed;
`endif
      end else if (r_state == ST_SHIFT) begin
        r_work <= w_step;
        r_cnt  <= r_cnt - SW'(1);
      end
      if (w_load) begin
        r_result <= w_res;
        r_za     <= w_za;
        r_zb     <= w_zb;
        r_eq     <= w_eq;
        r_gt     <= w_gt;
        r_lt     <= w_lt;
        r_zr     <= (w_res == '0);
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.za        = r_za;
  assign bus.zb        = r_zb;
  assign bus.eq        = r_eq;
  assign bus.gt        = r_gt;
  assign bus.lt        = r_lt;
  assign bus.zr        = r_zr;

endmodule

// File: tb/tb_logic_cmp_unit.sv
// Directed self-checking bench for logic_cmp_unit (WIDTH=16); signed cases need LOGIC_SIGNED_CMP_EN.
module tb_logic_cmp_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic_cmp_unit_if #(.WIDTH(16)) bus ();

  logic_cmp_unit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {bus.za, bus.zb, bus.eq, bus.gt, bus.lt, bus.zr};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] opc, input logic sgn);
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    bus.opcode   = opc;
`ifdef LOGIC_SIGNED_CMP_EN
    bus.cmp_signed = sgn;
`else
    if (sgn) $display("note: signed request issued without signed compare support");
`endif
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles from acceptance until out_valid; in_ready must stay low meanwhile.
  task automatic wait_done(input string tag, input int exp_lat);
    int   cyc = 1;
    logic rdy_seen = 1'b0;
    while (!bus.out_valid && cyc < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " in_ready low"}, {62'd0, rdy_seen, bus.in_ready}, 64'd0);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] res, input logic [5:0] fl);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, " result"}, 64'(bus.result), 64'(res));
    chk({tag, " flags"}, 64'(flags()), 64'(fl));
    chk({tag, " one-hot cmp"}, 64'(32'(bus.eq) + 32'(bus.gt) + 32'(bus.lt)), 64'd1);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, " idle after drain"}, {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [3:0] opc, input logic sgn, input int lat,
                    input logic [15:0] res, input logic [5:0] fl);
    issue(a, b, opc, sgn);
    wait_done(tag, lat);
    chk_res(tag, res, fl);
    drain(tag);
  endtask

  // flag vectors are {za, zb, eq, gt, lt, zr}
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op1       = 16'h1234;
    bus.op2       = 16'h0001;
    bus.opcode    = 4'd0;
    bus.out_ready = 1'b0;
`ifdef LOGIC_SIGNED_CMP_EN
    bus.cmp_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset result", 64'(bus.result), 64'd0);
    chk("reset flags", 64'(flags()), 64'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("no accept during reset", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

    op("AND",   16'hF0F0, 16'h0FF0, 4'd0,  1'b0, 1,  16'h00F0, 6'b000100);
    op("XOR0",  16'h0000, 16'h0000, 4'd5,  1'b0, 1,  16'h0000, 6'b111001);
    op("OR",    16'h1234, 16'h00FF, 4'd1,  1'b0, 1,  16'h12FF, 6'b000100);
    op("NOR",   16'h0F0F, 16'h00F0, 4'd2,  1'b0, 1,  16'hF000, 6'b000100);
    op("NOT1",  16'h00FF, 16'h00FF, 4'd3,  1'b0, 1,  16'hFF00, 6'b001000);
    op("NOT2",  16'h0001, 16'hFFFF, 4'd4,  1'b0, 1,  16'h0000, 6'b000011);
    op("XNOR",  16'hAAAA, 16'h5555, 4'd6,  1'b0, 1,  16'h0000, 6'b000101);
    op("OP7",   16'h0005, 16'h0005, 4'd7,  1'b0, 1,  16'h0000, 6'b001001);
    op("OP13",  16'h0003, 16'h0007, 4'd13, 1'b0, 1,  16'h0000, 6'b000011);
    op("SHL3",  16'h0001, 16'h0013, 4'd8,  1'b0, 4,  16'h0008, 6'b000010);
    op("ROL4",  16'h8001, 16'h0004, 4'd10, 1'b0, 5,  16'h0018, 6'b000100);
    op("ROR1",  16'h0001, 16'h0001, 4'd11, 1'b0, 2,  16'h8000, 6'b001000);
    op("SHR0",  16'hABCD, 16'h0000, 4'd9,  1'b0, 1,  16'hABCD, 6'b010100);
    op("SHR15", 16'h8000, 16'h000F, 4'd9,  1'b0, 16, 16'h0001, 6'b000100);
    op("SHL15", 16'h8001, 16'h000F, 4'd8,  1'b0, 16, 16'h8000, 6'b000100);
    op("UCMP",  16'hFFFF, 16'h0001, 4'd0,  1'b0, 1,  16'h0001, 6'b000100);
`ifdef LOGIC_SIGNED_CMP_EN
    op("SCMP",  16'hFFFF, 16'h0001, 4'd0,  1'b1, 1,  16'h0001, 6'b000010);
    op("SCMP0", 16'hFFFF, 16'h0001, 4'd0,  1'b0, 1,  16'h0001, 6'b000100);
`endif

    // Inputs offered while busy must be ignored.
    issue(16'h0001, 16'h0002, 4'd8, 1'b0);
    bus.in_valid = 1'b1;
    bus.op1      = 16'hFFFF;
    bus.op2      = 16'hFFFF;
    bus.opcode   = 4'd1;
    wait_done("BUSY", 3);
    chk_res("BUSY", 16'h0004, 6'b000010);
    bus.in_valid = 1'b0;
    drain("BUSY");

    issue(16'h00F0, 16'h0F00, 4'd1, 1'b0);
    wait_done("BP", 1);
    chk_res("BP", 16'h0FF0, 6'b000010);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("BP hold result", 64'(bus.result), 64'h0FF0);
      chk("BP hold flags", 64'(flags()), 64'(6'b000010));
      chk("BP hold handshake", {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
    end
    drain("BP");
    op("BPNEXT", 16'h0000, 16'h0001, 4'd3, 1'b0, 1, 16'hFFFF, 6'b100010);

    issue(16'h0001, 16'h0008, 4'd8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("MIDSHIFT busy", {62'd0, bus.out_valid, bus.in_ready}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("MIDRST out_valid", 64'(bus.out_valid), 64'd0);
    chk("MIDRST in_ready", 64'(bus.in_ready), 64'd1);
    chk("MIDRST result", 64'(bus.result), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("MIDRST no result", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
